// File: rtl/div_issue_ctrl_pkg.sv
// ============================================================================
// div_issue_ctrl_pkg : shared state encoding and latency defaults for the
//                      EX-stage divider requester.
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_issue_ctrl_pkg;

    localparam int DIV_CYCLES_DEF     = 36;
    localparam int TIMEOUT_CYCLES_DEF = 40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } div_state_e;

    // Counter must represent the larger of the two latencies.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_issue_ctrl_if.sv
// ============================================================================
// div_issue_ctrl_if : EX-stage request side and divider start/done side of
//                     the divide issue controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface div_issue_ctrl_if;

    logic        ex_div_valid;
    logic        ex_div_unsigned;
    logic [31:0] ex_opa;
    logic [31:0] ex_opb;
    logic        ex_flush;
    logic        ex_allowout;

    logic        div_start;
    logic        div_unsigned;
    logic [31:0] div_opa;
    logic [31:0] div_opb;
    logic [63:0] div_result;
    logic        div_done;

    logic        stall_req;
    logic        hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        div_timeout;

    modport master (
        input  ex_div_valid, ex_div_unsigned, ex_opa, ex_opb, ex_flush, ex_allowout,
        input  div_result, div_done,
        output div_start, div_unsigned, div_opa, div_opb,
        output stall_req, hilo_we, hi_wdata, lo_wdata, div_timeout
    );

    modport slave (
        output ex_div_valid, ex_div_unsigned, ex_opa, ex_opb, ex_flush, ex_allowout,
        output div_result, div_done,
        input  div_start, div_unsigned, div_opa, div_opb,
        input  stall_req, hilo_we, hi_wdata, lo_wdata, div_timeout
    );

endinterface

`default_nettype wire

// File: rtl/div_issue_ctrl.sv
// ============================================================================
// div_issue_ctrl : issues DIV/DIVU to the multi-cycle divider, stalls EX until
//                  done, and commits {HI,LO} when the instruction leaves EX.
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES     = DIV_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  wire logic     clock,
    input  wire logic     reset,
    div_issue_ctrl_if.master bus
);

    localparam int              CNT_W        = cnt_width(DIV_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic             uns_q, uns_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             timeout_q, timeout_d;

    logic             start_w;
    logic             stall_w;
    logic             hilo_we_w;
    logic             req_w;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            uns_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            uns_q     <= uns_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        opa_d     = opa_q;
        opb_d     = opb_q;
        uns_d     = uns_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        timeout_d = timeout_q;
        start_w   = 1'b0;
        stall_w   = 1'b0;
        hilo_we_w = 1'b0;
        req_w     = bus.ex_div_valid & ~bus.ex_flush;

        case (state_q)
            ST_IDLE: begin
                // Always at least one start-low cycle here before re-entering BUSY.
                stall_w = req_w;
                if (req_w) begin
                    opa_d   = bus.ex_opa;
                    opb_d   = bus.ex_opb;
                    uns_d   = bus.ex_div_unsigned;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                start_w = 1'b1;
                stall_w = 1'b1;
                if (bus.ex_flush) begin
                    state_d = ST_IDLE;
                end else if (bus.div_done) begin
                    hi_d    = bus.div_result[63:32];
                    lo_d    = bus.div_result[31:0];
                    state_d = ST_HOLD;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                hilo_we_w = bus.ex_allowout & ~bus.ex_flush;
                if (bus.ex_allowout | bus.ex_flush) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.div_start    = start_w;
    assign bus.div_unsigned = uns_q;
    assign bus.div_opa      = opa_q;
    assign bus.div_opb      = opb_q;
    assign bus.stall_req    = stall_w;
    assign bus.hilo_we      = hilo_we_w;
    assign bus.hi_wdata     = hi_q;
    assign bus.lo_wdata     = lo_q;
    assign bus.div_timeout  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
// ============================================================================
// tb_div_issue_ctrl : self-checking bench for div_issue_ctrl with a
//                     behavioural divider and a timing-rule reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_issue_ctrl;

    localparam int DIV_CYCLES     = 36;
    localparam int TIMEOUT_CYCLES = 40;
    localparam int LAST_BUSY      = DIV_CYCLES + 1;
    localparam int LAT            = DIV_CYCLES + 2;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    logic exp_timeout;
    logic dead;
    logic stray;
    int   dcnt;

    typedef struct {
        logic [31:0] opa;
        logic [31:0] opb;
        logic        uns;
        int          hold;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[7];

    div_issue_ctrl_if bus_if ();

    div_issue_ctrl #(
        .DIV_CYCLES     (DIV_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic u);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (u) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // Divider: counts start-high edges, answers after DIV_CYCLES of them.
    always @(posedge clock) begin
        if (!bus_if.div_start) dcnt <= 0;
        else                   dcnt <= dcnt + 1;
    end

    logic model_done;
    assign model_done        = bus_if.div_start && (dcnt == DIV_CYCLES) && !dead;
    assign bus_if.div_done   = model_done | stray;
    assign bus_if.div_result = model_done
                             ? ref_div(bus_if.div_opa, bus_if.div_opb, bus_if.div_unsigned)
                             : ref_div(bus_if.div_opa, bus_if.div_opb, bus_if.div_unsigned)
                               ^ 64'hA5A5_5A5A_C3C3_3C3C;

    task automatic chk(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%h expected=%h t=%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".div_start"},    0, 64'(bus_if.div_start),    64'd0);
        chk({tag, ".div_unsigned"}, 0, 64'(bus_if.div_unsigned), 64'd0);
        chk({tag, ".div_opa"},      0, 64'(bus_if.div_opa),      64'd0);
        chk({tag, ".div_opb"},      0, 64'(bus_if.div_opb),      64'd0);
        chk({tag, ".hilo_we"},      0, 64'(bus_if.hilo_we),      64'd0);
        chk({tag, ".hi_wdata"},     0, 64'(bus_if.hi_wdata),     64'd0);
        chk({tag, ".lo_wdata"},     0, 64'(bus_if.lo_wdata),     64'd0);
        chk({tag, ".div_timeout"},  0, 64'(bus_if.div_timeout),  64'd0);
        chk({tag, ".stall_req"},    0, 64'(bus_if.stall_req),    64'd0);
    endtask

    task automatic drive_idle();
        bus_if.ex_div_valid = 1'b0;
        bus_if.ex_flush     = 1'b0;
        bus_if.ex_allowout  = 1'b0;
        stray               = 1'b0;
    endtask

    // One instruction from request (k=0) until it leaves EX or is flushed.
    task automatic run_op(input logic [31:0] opa, input logic [31:0] opb, input logic uns,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int hold, input int flush_at);
        int kend;
        kend = (flush_at >= 0) ? flush_at : LAT + hold;
        for (int k = 0; k <= kend; k++) begin
            bus_if.ex_div_valid    = 1'b1;
            bus_if.ex_opa          = (k == 0) ? opa : $urandom;
            bus_if.ex_opb          = (k == 0) ? opb : $urandom;
            bus_if.ex_div_unsigned = (k == 0) ? uns : 1'($urandom);
            bus_if.ex_flush        = (k == flush_at);
            bus_if.ex_allowout     = (flush_at < 0) && (k == LAT + hold);
            stray                  = (k == LAT + 1) && (hold >= 2);
            @(negedge clock);
            chk("div_start", k, 64'(bus_if.div_start), 64'(k >= 1 && k <= LAST_BUSY));
            chk("stall_req", k, 64'(bus_if.stall_req), 64'(k <= LAST_BUSY));
            chk("hilo_we",   k, 64'(bus_if.hilo_we),   64'(flush_at < 0 && k == LAT + hold));
            chk("div_timeout", k, 64'(bus_if.div_timeout), 64'(exp_timeout));
            if (k >= 1 && k <= LAST_BUSY) begin
                chk("div_opa",      k, 64'(bus_if.div_opa),      64'(opa));
                chk("div_opb",      k, 64'(bus_if.div_opb),      64'(opb));
                chk("div_unsigned", k, 64'(bus_if.div_unsigned), 64'(uns));
            end
            if (k >= LAT) begin
                chk("hi_wdata", k, 64'(bus_if.hi_wdata), 64'(ehi));
                chk("lo_wdata", k, 64'(bus_if.lo_wdata), 64'(elo));
            end
            @(posedge clock);
            #1;
        end
        drive_idle();
    endtask

    task automatic idle_cycles(input int n, input logic with_stray, input logic killed_req);
        for (int k = 0; k < n; k++) begin
            bus_if.ex_div_valid = killed_req;
            bus_if.ex_flush     = killed_req;
            bus_if.ex_opa       = $urandom;
            stray               = with_stray;
            @(negedge clock);
            chk("idle.stall_req", k, 64'(bus_if.stall_req), 64'd0);
            chk("idle.div_start", k, 64'(bus_if.div_start), 64'd0);
            chk("idle.hilo_we",   k, 64'(bus_if.hilo_we),   64'd0);
            @(posedge clock);
            #1;
        end
        drive_idle();
    endtask

    initial begin
        logic [63:0] r;
        logic [31:0] a;
        logic [31:0] b;
        logic        u;
        int          hold;
        int          fl;

        checks      = 0;
        failures    = 0;
        exp_timeout = 1'b0;
        dead        = 1'b0;
        stray       = 1'b0;
        reset       = 1'b1;
        bus_if.ex_opa          = '0;
        bus_if.ex_opb          = '0;
        bus_if.ex_div_unsigned = 1'b0;
        drive_idle();

        vecs[0] = '{32'hFFFF_FFF9, 32'd2,          1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[1] = '{32'hFFFF_FFFF, 32'h10,         1'b1, 0, 32'h0000_000F, 32'h0FFF_FFFF};
        vecs[2] = '{32'd100,       32'd7,          1'b0, 5, 32'd2,         32'd14};
        vecs[3] = '{32'd7,         32'hFFFF_FFFE,  1'b0, 2, 32'd1,         32'hFFFF_FFFD};
        vecs[4] = '{32'h8000_0000, 32'd3,          1'b1, 0, 32'd2,         32'h2AAA_AAAA};
        vecs[5] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9,  1'b0, 1, 32'hFFFF_FFFE, 32'd14};
        vecs[6] = '{32'd5,         32'd0,          1'b1, 0, 32'd5,         32'hFFFF_FFFF};

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk_zero("reset");
        @(posedge clock);
        #1;

        // Back-to-back table vectors.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].opa, vecs[i].opb, vecs[i].uns, vecs[i].hi, vecs[i].lo,
                   vecs[i].hold, -1);
        end

        idle_cycles(2, 1'b1, 1'b0);
        idle_cycles(1, 1'b0, 1'b1);

        // Flush at 10th BUSY cycle, then an immediate new request.
        run_op(32'd1234, 32'd5, 1'b0, 32'd0, 32'd0, 0, 10);
        run_op(vecs[1].opa, vecs[1].opb, vecs[1].uns, vecs[1].hi, vecs[1].lo, 0, -1);

        // Divider never answers.
        dead = 1'b1;
        for (int k = 0; k <= TIMEOUT_CYCLES; k++) begin
            bus_if.ex_div_valid    = 1'b1;
            bus_if.ex_opa          = 32'd99;
            bus_if.ex_opb          = 32'd3;
            bus_if.ex_div_unsigned = 1'b1;
            @(negedge clock);
            chk("to.div_start",   k, 64'(bus_if.div_start),   64'(k >= 1));
            chk("to.stall_req",   k, 64'(bus_if.stall_req),   64'd1);
            chk("to.div_timeout", k, 64'(bus_if.div_timeout), 64'd0);
            chk("to.hilo_we",     k, 64'(bus_if.hilo_we),     64'd0);
            @(posedge clock);
            #1;
        end
        drive_idle();
        exp_timeout = 1'b1;
        @(negedge clock);
        chk("to.div_timeout_set", 0, 64'(bus_if.div_timeout), 64'd1);
        chk("to.stall_after",     0, 64'(bus_if.stall_req),   64'd0);
        chk("to.start_after",     0, 64'(bus_if.div_start),   64'd0);
        @(posedge clock);
        #1;
        dead = 1'b0;
        run_op(vecs[0].opa, vecs[0].opb, vecs[0].uns, vecs[0].hi, vecs[0].lo, 0, -1);

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            a    = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            u    = 1'($urandom);
            hold = $urandom_range(0, 3);
            fl   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, LAT + hold) : -1;
            r    = ref_div(a, b, u);
            run_op(a, b, u, r[63:32], r[31:0], hold, fl);
            case ($urandom_range(0, 3))
                0: idle_cycles($urandom_range(1, 2), 1'b0, 1'b0);
                1: idle_cycles(1, 1'b1, 1'b0);
                2: idle_cycles(1, 1'b0, 1'b1);
                default: ;
            endcase
        end

        // Reset in the middle of BUSY.
        for (int k = 0; k < 10; k++) begin
            bus_if.ex_div_valid    = 1'b1;
            bus_if.ex_opa          = 32'hDEAD_BEEF;
            bus_if.ex_opb          = 32'h0000_0013;
            bus_if.ex_div_unsigned = 1'b1;
            @(posedge clock);
            #1;
        end
        drive_idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset       = 1'b0;
        exp_timeout = 1'b0;
        @(negedge clock);
        chk_zero("midreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
